// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor-0 register file (SR/Cause/EPC/PRId) and exception/interrupt sequencer.
// Define CP0_TIMER_EN to add the Count (9) / Compare (11) timer feeding HWInt[5].
module cp0_unit #(
   parameter logic [31:0] PRID_VALUE = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] M_PC,
   input  logic        M_BD,
   input  logic        M_exc,
   input  logic [4:0]  M_ExcCode,
   input  logic        M_eret,
   input  logic [5:0]  HWInt,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra,
   output logic [31:0] rd,
   output logic        req,
   output logic [31:0] EPC_out
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned NINT = 6;
   localparam int unsigned RW   = 5;

   localparam logic [RW-1:0] REG_COUNT   = RW'(9);
   localparam logic [RW-1:0] REG_COMPARE = RW'(11);
   localparam logic [RW-1:0] REG_SR      = RW'(12);
   localparam logic [RW-1:0] REG_CAUSE   = RW'(13);
   localparam logic [RW-1:0] REG_EPC     = RW'(14);
   localparam logic [RW-1:0] REG_PRID    = RW'(15);

   // The FSM state is SR.EXL itself.
   typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [NINT-1:0] im_q, im_d;
   logic            ie_q, ie_d;
   logic            bd_q, bd_d;
   logic [NINT-1:0] ip_q, ip_d;
   logic [RW-1:0]   exc_code_q, exc_code_d;
   logic [XLEN-1:0] epc_q, epc_d;

   logic [NINT-1:0] hw_eff;
   logic            exl;
   logic            int_req;
   logic            exc_req;
   logic            take;
   logic            wr_en;

`ifdef CP0_TIMER_EN
   logic [XLEN-1:0] count_q, count_d;
   logic [XLEN-1:0] compare_q, compare_d;
   logic            pend_q, pend_d;

   assign hw_eff = {HWInt[NINT-1] | pend_q, HWInt[NINT-2:0]};
`else
   assign hw_eff = HWInt;
`endif

   assign exl     = (state_q == HANDLER);
   assign int_req = ie_q & ~exl & (|(im_q & hw_eff));
   assign exc_req = M_exc & ~exl;
   assign take    = int_req | exc_req;
   // A take this cycle swallows any concurrent mtc0.
   assign wr_en   = we & ~take;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= NORMAL;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL: begin
            if (take)                                 state_d = HANDLER;
            else if (wr_en && wa == REG_SR && wd[1])  state_d = HANDLER;
         end
         HANDLER: begin
            if (M_eret)                               state_d = NORMAL;
            else if (wr_en && wa == REG_SR && !wd[1]) state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
   end

   // Register-file next values (everything except EXL).
   always_comb begin
      im_d       = im_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = hw_eff;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (take) begin
         bd_d       = M_BD;
         exc_code_d = int_req ? RW'(0) : M_ExcCode;
         epc_d      = M_BD ? (M_PC - XLEN'(4)) : M_PC;
      end else if (wr_en) begin
         if (wa == REG_SR) begin
            im_d = wd[15:10];
            ie_d = wd[0];
         end
         if (wa == REG_EPC) epc_d = wd;
      end
   end

`ifdef CP0_TIMER_EN
   always_comb begin
      count_d   = count_q + XLEN'(1);
      compare_d = compare_q;
      pend_d    = pend_q | (count_q == compare_q);
      if (wr_en && wa == REG_COUNT) count_d = wd;
      if (wr_en && wa == REG_COMPARE) begin
         compare_d = wd;
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         compare_q <= '1;
         pend_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         im_q       <= '0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         im_q       <= im_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // Outputs: read port shows pre-write contents.
   always_comb begin
      req     = take;
      EPC_out = epc_q;
      rd      = '0;
      case (ra)
         REG_SR:    rd = {16'b0, im_q, 8'b0, exl, ie_q};
         REG_CAUSE: rd = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
         REG_EPC:   rd = epc_q;
         REG_PRID:  rd = PRID_VALUE;
`ifdef CP0_TIMER_EN
         REG_COUNT:   rd = count_q;
         REG_COMPARE: rd = compare_q;
`endif
         default:   rd = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed table, hand sequences and randomized model comparison for cp0_unit.
module tb_cp0_unit;
   localparam logic [31:0] TB_PRID = 32'h0001_9302;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] m_pc;
   logic        m_bd, m_exc, m_eret;
   logic [4:0]  m_code;
   logic [5:0]  hw;
   logic        we;
   logic [4:0]  wa, ra;
   logic [31:0] wd, rd, epc_out;
   logic        req;

   int checks = 0;
   int errors = 0;

   cp0_unit #(.PRID_VALUE(TB_PRID)) dut (
      .clk(clk), .reset_n(reset_n), .M_PC(m_pc), .M_BD(m_bd), .M_exc(m_exc),
      .M_ExcCode(m_code), .M_eret(m_eret), .HWInt(hw), .we(we), .wa(wa), .wd(wd),
      .ra(ra), .rd(rd), .req(req), .EPC_out(epc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [5:0]  hw;
      logic        exc;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] pc;
      logic        eret;
      logic        exp_req;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[19];

   // Reference model state (architectural register words)
   logic [31:0] m_sr, m_cause, m_epc;
`ifdef CP0_TIMER_EN
   logic [31:0] m_count, m_cmp;
   logic        m_pend;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r_a, input logic [5:0] h, input logic e,
                        input logic [4:0] c, input logic b, input logic [31:0] p,
                        input logic er);
      we = w; wa = a; wd = d; ra = r_a; hw = h; m_exc = e; m_code = c;
      m_bd = b; m_pc = p; m_eret = er;
   endtask

   task automatic idle(input logic [4:0] r_a);
      drive(1'b0, 5'd0, 32'd0, r_a, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset_n = 1'b0;
      idle(5'd0);
      tick;
      reset_n = 1'b1;
   endtask

   task automatic model_reset;
      m_sr = '0; m_cause = '0; m_epc = '0;
`ifdef CP0_TIMER_EN
      m_count = '0; m_cmp = '1; m_pend = 1'b0;
`endif
   endtask

   function automatic logic [5:0] model_hw();
      logic [5:0] h = hw;
`ifdef CP0_TIMER_EN
      if (m_pend) h[5] = 1'b1;
`endif
      return h;
   endfunction

   function automatic logic model_int();
      logic [5:0] im = m_sr[15:10];
      return m_sr[0] && !m_sr[1] && ((im & model_hw()) != 6'd0);
   endfunction

   function automatic logic model_req();
      return model_int() || (m_exc && !m_sr[1]);
   endfunction

   function automatic logic [31:0] model_rd();
      case (ra)
         5'd12: return m_sr;
         5'd13: return m_cause;
         5'd14: return m_epc;
         5'd15: return TB_PRID;
`ifdef CP0_TIMER_EN
         5'd9:  return m_count;
         5'd11: return m_cmp;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step;
      logic        r, intr, w, old_exl;
      logic [31:0] nc;
      r       = model_req();
      intr    = model_int();
      w       = we && !r;
      old_exl = m_sr[1];
      nc      = {m_cause[31:16], model_hw(), m_cause[9:0]};
`ifdef CP0_TIMER_EN
      begin
         logic [31:0] cn;
         logic        pn;
         cn = (w && wa == 5'd9) ? wd : m_count + 32'd1;
         pn = (w && wa == 5'd11) ? 1'b0 : (m_pend || m_count == m_cmp);
         if (w && wa == 5'd11) m_cmp = wd;
         m_count = cn;
         m_pend  = pn;
      end
`endif
      if (r) begin
         m_sr[1]  = 1'b1;
         nc[31]   = m_bd;
         nc[6:2]  = intr ? 5'd0 : m_code;
         m_epc    = m_bd ? m_pc - 32'd4 : m_pc;
      end else begin
         if (w && wa == 5'd12) m_sr = wd & 32'h0000_FC03;
         if (w && wa == 5'd14) m_epc = wd;
         if (m_eret && old_exl) m_sr[1] = 1'b0;
      end
      m_cause = nc;
   endtask

   initial begin
      logic [4:0] regs[8];
      reset_n = 1'b0;
      idle(5'd0);
      regs[0] = 5'd9;  regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd13;
      regs[4] = 5'd14; regs[5] = 5'd15; regs[6] = 5'd3;  regs[7] = 5'd0;

      //        we    wa     wd            ra     hw     exc   code    bd    pc             eret  req   rd
      tbl[0]  = '{1'b0, 5'd0,  32'd0,        5'd12, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[1]  = '{1'b0, 5'd0,  32'd0,        5'd13, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[2]  = '{1'b0, 5'd0,  32'd0,        5'd14, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[3]  = '{1'b1, 5'd12, 32'h401,      5'd12, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[4]  = '{1'b0, 5'd0,  32'd0,        5'd12, 6'd1,  1'b0, 5'd0,  1'b0, 32'h3008,      1'b0, 1'b1, 32'h401};
      tbl[5]  = '{1'b0, 5'd0,  32'd0,        5'd14, 6'd1,  1'b1, 5'd7,  1'b0, 32'h4000,      1'b0, 1'b0, 32'h3008};
      tbl[6]  = '{1'b0, 5'd0,  32'd0,        5'd13, 6'd1,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h400};
      tbl[7]  = '{1'b0, 5'd0,  32'd0,        5'd12, 6'd1,  1'b0, 5'd0,  1'b0, 32'd0,         1'b1, 1'b0, 32'h403};
      tbl[8]  = '{1'b1, 5'd14, 32'hDEADBEEF, 5'd12, 6'd1,  1'b0, 5'd0,  1'b0, 32'h3020,      1'b0, 1'b1, 32'h401};
      tbl[9]  = '{1'b0, 5'd0,  32'd0,        5'd14, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h3020};
      tbl[10] = '{1'b0, 5'd0,  32'd0,        5'd13, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b1, 1'b0, 32'd0};
      tbl[11] = '{1'b0, 5'd0,  32'd0,        5'd12, 6'd0,  1'b1, 5'd12, 1'b1, 32'h3010,      1'b0, 1'b1, 32'h401};
      tbl[12] = '{1'b0, 5'd0,  32'd0,        5'd13, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h8000_0030};
      tbl[13] = '{1'b0, 5'd0,  32'd0,        5'd14, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h300C};
      tbl[14] = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd15, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, TB_PRID};
      tbl[15] = '{1'b0, 5'd0,  32'd0,        5'd13, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h8000_0030};
      tbl[16] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[17] = '{1'b1, 5'd14, 32'h1234,     5'd3,  6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'd0};
      tbl[18] = '{1'b0, 5'd0,  32'd0,        5'd14, 6'd0,  1'b0, 5'd0,  1'b0, 32'd0,         1'b0, 1'b0, 32'h1234};

      do_reset;
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].hw, tbl[i].exc,
               tbl[i].code, tbl[i].bd, tbl[i].pc, tbl[i].eret);
         #1;
         check($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].exp_req));
         check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         if (tbl[i].ra == 5'd14) check($sformatf("tbl%0d_epc_out", i), epc_out, tbl[i].exp_rd);
         tick;
      end

      // Asynchronous reset while in the handler
      idle(5'd12);
      #1 check("pre_rst_sr", rd, 32'h403);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_sr", rd, 32'd0);
      check("async_rst_req", 32'(req), 32'd0);
      check("async_rst_epc", epc_out, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef CP0_TIMER_EN
      do_reset;
      drive(1'b1, 5'd12, 32'h8001, 5'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0); tick;
      drive(1'b1, 5'd9,  32'd0,    5'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0); tick;
      drive(1'b1, 5'd11, 32'd5,    5'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'h5000, 1'b0); tick;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 5'd0, 32'd0, 5'd9, 6'd0, 1'b0, 5'd0, 1'b0, 32'h5000, 1'b0);
         #1;
         check($sformatf("tmr_cnt%0d", i), rd, 32'(i));
         check($sformatf("tmr_noreq%0d", i), 32'(req), 32'd0);
         tick;
      end
      drive(1'b0, 5'd0, 32'd0, 5'd9, 6'd0, 1'b0, 5'd0, 1'b0, 32'h5000, 1'b0);
      #1;
      check("tmr_req", 32'(req), 32'd1);
      check("tmr_cnt6", rd, 32'd6);
      tick;
      idle(5'd13);
      #1 check("tmr_cause", rd, 32'h0000_8000);
      tick;
      drive(1'b1, 5'd11, 32'd1000, 5'd12, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      #1 check("tmr_sr_exl", rd, 32'h8003);
      tick;
      drive(1'b0, 5'd0, 32'd0, 5'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1); tick;
      idle(5'd12);
      #1;
      check("tmr_cleared_req", 32'(req), 32'd0);
      check("tmr_after_eret_sr", rd, 32'h8001);
      tick;
`endif

      // Randomized run against the reference model
      do_reset;
      model_reset;
      for (int n = 0; n < 3000; n++) begin
         logic [4:0]  a;
         logic [31:0] d;
         a = regs[$urandom_range(0, 7)];
         case (a)
            5'd9:    d = 32'($urandom_range(0, 20));
            5'd11:   d = 32'($urandom_range(0, 40));
            5'd12:   d = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FC01);
            default: d = $urandom;
         endcase
         drive($urandom_range(0, 3) == 0, a, d, regs[$urandom_range(0, 7)],
               ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
               $urandom_range(0, 5) == 0, 5'($urandom), 1'($urandom),
               {$urandom, 2'b00} >> 2 << 2, $urandom_range(0, 3) == 0);
         #1;
         check("rnd_req", 32'(req), 32'(model_req()));
         check("rnd_rd", rd, model_rd());
         check("rnd_epc_out", epc_out, m_epc);
         @(posedge clk);
         model_step;
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 register file and exception/interrupt sequencer for the five-stage MIPS pipeline. Sits beside the M stage: it samples the M-stage PC, branch-delay flag and exception code, and decides each cycle whether to take an interrupt or exception. On a take it latches EPC/Cause/SR and raises a flush request; on `eret` it releases EXL and supplies the return address. It also serves `mfc0`/`mtc0`.

## Interface
- `PRID_VALUE`, default 32'h0000_0001, constant read from register 15.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `M_PC`  in  32  PC of the instruction in M.
- `M_BD`  in  1  M instruction is in a branch/jump delay slot (pipelined delay-slot flag).
- `M_exc`  in  1  M instruction carries an exception.
- `M_ExcCode`  in  5  exception code for `M_exc`.
- `M_eret`  in  1  M instruction is `eret`.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `we`  in  1  `mtc0` in M.
- `wa`  in  5  write register number.
- `wd`  in  32  write data.
- `ra`  in  5  read register number.
- `rd`  out  32  read data, combinational.
- `req`  out  1  take exception/interrupt this cycle; pipeline flushes and fetches the handler.
- `EPC_out`  out  32  current EPC, used as the `eret` target.

## Operation
- Registers: SR (12), Cause (13), EPC (14), PRId (15). Unlisted numbers read 0; writes ignored.
- SR writable fields: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]; read-only to `mtc0` (writes dropped).
- EPC fully writable by `mtc0`.
- IP[15:10] <= `HWInt` every cycle, regardless of other events.
- int_req = IE & ~EXL & |(IM & HWInt). exc_req = `M_exc` & ~EXL. `req` = int_req | exc_req.
- Interrupt has priority over exception in the same cycle.
- Two states, encoded by SR.EXL: NORMAL (EXL=0) and HANDLER (EXL=1).
- NORMAL -> HANDLER on `req`: EXL<=1; ExcCode<=0 (interrupt) or `M_ExcCode`; BD<=`M_BD`; EPC<=`M_BD` ? `M_PC`-4 : `M_PC`.
- HANDLER -> NORMAL on `M_eret`: EXL<=0; no other field changes.
- In HANDLER, `req` stays 0 regardless of inputs.
- `req` and `we` same cycle: `req` wins; the write is discarded.
- `we` to SR with EXL=1 allowed; new EXL takes effect next cycle.
- `rd` reflects the register contents before any write this cycle (no bypass).

## Timing
- All register updates occur on the rising `clk` edge after the qualifying cycle; `req` is combinational from inputs and current state.
- `EPC_out` valid the cycle after the take; an `eret` reading it is always at least one cycle later.
- `reset_n` low: SR, Cause, EPC = 0; state NORMAL; `req` = 0 while `M_exc` = 0. Reset mid-handler returns to NORMAL immediately, not waiting for a clock edge.
- PRId is constant and unaffected by reset.

## Configuration
- `CP0_TIMER_EN` defined: Count (9) and Compare (11) implemented. Count increments every cycle and wraps from 32'hFFFF_FFFF to 0. An `mtc0` to Count loads `wd` instead of incrementing that cycle. A timer-pending flag is set when the registered Count equals Compare, stays set until Compare is written, and is ORed into `HWInt[5]` before IP sampling and int_req. Reset: Count = 0, Compare = 32'hFFFF_FFFF, pending = 0.
- Undefined: registers 9 and 11 read 0, writes ignored; no timer logic.

## Test plan
- Reset, then `mtc0` SR = 32'h0000_0401, `HWInt` = 6'b000001, `M_PC` = 32'h3008, `M_BD` = 0 -> `req` = 1; next cycle EPC = 32'h3008, Cause.ExcCode = 0, SR.EXL = 1.
- NORMAL, `M_exc` = 1, `M_ExcCode` = 5'd12, `M_BD` = 1, `M_PC` = 32'h3010 -> `req` = 1; EPC = 32'h300C, Cause = 32'h8000_0030.
- EXL = 1, `M_exc` = 1 and unmasked `HWInt` -> `req` = 0, EPC unchanged; then `M_eret` -> EXL = 0 next cycle, pending interrupt gives `req` = 1 the following cycle.
- Same cycle `req` = 1 and `we` = 1 to EPC with `wd` = 32'hDEAD_BEEF -> EPC = faulting PC, not DEADBEEF.
- `mtc0` Cause = 32'hFFFF_FFFF -> Cause unchanged; read of reg 15 -> `PRID_VALUE`; read of reg 3 -> 0.
- With `CP0_TIMER_EN`: SR = 32'h8001 (IM[15], IE), Count <= 0, Compare <= 5 -> pending set when Count = 5, `req` asserts the next cycle; writing Compare clears it.
